iir_dir_pole: RTL
=================

IIR_DIR_POLE -- requirements
Module: iir_dir_pole

Interface
REQ-001 SHALL have parameter COEF_FRAC, default 12: fractional bits of pole coefficients and of the incoming zero-section product.
REQ-002 SHALL have parameter ACC_W, default 56: internal accumulator width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: Xin carries a new sample.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts a sample this cycle.
REQ-007 SHALL have port Xin, input, signed 48 bits: zero-section output (numerator sum), scaled by 2^COEF_FRAC.
REQ-008 SHALL have port coef_we, input, 1 bit: coefficient write strobe.
REQ-009 SHALL have port coef_addr, input, 3 bits: coefficient index k, 1..7; 0 is ignored.
REQ-010 SHALL have port coef_data, input, signed 16 bits: coefficient A_k in Q(16-COEF_FRAC).COEF_FRAC.
REQ-011 SHALL have port clr, input, 1 bit: synchronous clear of history and sat_flag.
REQ-012 SHALL have port Yout, output, signed 32 bits: filter output sample.
REQ-013 SHALL have port out_valid, output, 1 bit: one-cycle strobe marking a new Yout.
REQ-014 SHALL have port sat_flag, output, 1 bit: sticky saturation indicator.

Function
REQ-015 SHALL compute Y[n] = sat32(round((Xin - sum over k=1..7 of A_k*Y[n-k]) / 2^COEF_FRAC)), with rounding by adding 2^(COEF_FRAC-1) then arithmetic right shift.
REQ-016 SHALL hold Y[n-1]..Y[n-7] in a 7-entry 32-bit history shift register; Y[n] shifts in at the OUT state.
REQ-017 SHALL use one 16x32 signed multiplier, time-multiplexed across the 7 taps.
REQ-018 SHALL implement FSM states IDLE -> MAC -> OUT -> IDLE.
REQ-019 IDLE: in_ready=1; on in_valid, SHALL load acc with sign-extended Xin, set k=1, latch shadow coefficients into the active bank, and go to MAC.
REQ-020 MAC: SHALL perform acc -= A_k*Y[n-k], one tap per cycle for k=1..7, then go to OUT.
REQ-021 OUT: SHALL round, saturate and register Yout, pulse out_valid, shift history, and return to IDLE.
REQ-022 For a sample accepted at edge E, Yout/out_valid SHALL update at edge E+8; next acceptance earliest at edge E+9; in_ready SHALL be 0 from E through E+8.
REQ-023 Saturation SHALL clamp to +2^31-1 / -2^31 and set sat_flag; sat_flag SHALL hold until clr or reset.
REQ-024 coef_we SHALL write the shadow bank in any state; the active bank SHALL change only at sample acceptance, so a write during MAC affects the next sample only.
REQ-025 If a write and an acceptance coincide on the same edge, the active bank SHALL take the newly written value.
REQ-026 clr in IDLE SHALL zero the history and sat_flag; clr in MAC/OUT SHALL abort the sample (no out_valid) and return to IDLE with history zeroed.
REQ-027 Yout SHALL hold its last value between strobes.

Reset
REQ-028 On rst_n low, SHALL asynchronously set FSM to IDLE, zero history, acc, Yout, out_valid, sat_flag, and both coefficient banks, and set in_ready=1 once released.
REQ-029 Reset asserted mid-MAC SHALL discard the sample with no out_valid.

Structure
REQ-030 Shared package iir_pkg SHALL hold widths (48-bit Xin, 32-bit Y, 16-bit coefficient), tap count 7, and FSM state encodings.
REQ-031 The coefficient shadow/active bank SHALL be one sub-module, iir_pole_coef_bank.

Verification
REQ-032 All A_k=0, Xin=409600 -> Yout=100, out_valid at E+8, sat_flag=0.
REQ-033 A1=-2048, others 0; Xin impulse 4096000 then zeros -> Yout sequence 1000, 500, 250, 125, 63, 32.
REQ-034 Xin=2^47-1 with A=0 -> Yout=2147483647, sat_flag=1, held until clr pulse.
REQ-035 in_valid held high continuously -> acceptances at E, E+9, E+18; in_ready low for 8 edges each time.
REQ-036 Write A1=-2048 during MAC of sample 1 -> sample 1 uses old A1=0, sample 2 uses -2048.
REQ-037 rst_n pulsed low at MAC tap 4 -> no out_valid, in_ready=1, next impulse reproduces REQ-033 from 1000.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared widths, tap count and FSM state encoding for the direct-form pole section.
package iir_pkg;
  localparam int X_W  = 48;          // zero-section sum width
  localparam int Y_W  = 32;          // output / history sample width
  localparam int C_W  = 16;          // pole coefficient width
  localparam int P_W  = C_W + Y_W;   // full multiplier product width
  localparam int TAPS = 7;           // number of feedback taps

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_OUT
  } state_t;
endpackage

// File: rtl/iir_pole_coef_bank.sv
// Shadow/active coefficient bank: writes land in shadow, active copies at sample acceptance.
module iir_pole_coef_bank
  import iir_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [2:0]            addr,
  input  logic signed [C_W-1:0] data,
  input  logic                  latch,
  input  logic [2:0]            sel,
  output logic signed [C_W-1:0] coef
);

  logic signed [C_W-1:0] shadow [TAPS];
  logic signed [C_W-1:0] active [TAPS];

  // Shadow write and active latch; a write coincident with a latch goes straight to active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        if (we && addr == 3'(i + 1))
          shadow[i] <= data;
        if (latch)
          active[i] <= (we && addr == 3'(i + 1)) ? data : shadow[i];
      end
    end
  end

  // Active coefficient read for tap index sel (1..7); index 0 reads as zero.
  always_comb begin
    coef = '0;
    for (int unsigned i = 0; i < TAPS; i++)
      if (sel == 3'(i + 1))
        coef = active[i];
  end

endmodule

// File: rtl/iir_dir_pole.sv
// Direct-form IIR pole section: one shared multiplier walks the 7 feedback taps per sample.
module iir_dir_pole
  import iir_pkg::*;
#(
  parameter int COEF_FRAC = 12,
  parameter int ACC_W     = 56
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [X_W-1:0] Xin,
  input  logic                  coef_we,
  input  logic [2:0]            coef_addr,
  input  logic signed [C_W-1:0] coef_data,
  input  logic                  clr,
  output logic signed [Y_W-1:0] Yout,
  output logic                  out_valid,
  output logic                  sat_flag
);

  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (COEF_FRAC - 1);
  localparam logic signed [ACC_W-1:0] YMAX = {{(ACC_W-31){1'b0}}, {31{1'b1}}};
  localparam logic signed [ACC_W-1:0] YMIN = {{(ACC_W-31){1'b1}}, {31{1'b0}}};

  state_t                  state, next;
  logic [2:0]              k;
  logic signed [ACC_W-1:0] acc;
  logic signed [Y_W-1:0]   hist [TAPS];
  logic signed [Y_W-1:0]   hist_sel;
  logic signed [C_W-1:0]   coef;
  logic signed [P_W-1:0]   prod;
  logic signed [ACC_W-1:0] sum, rnd;
  logic                    sat_hi, sat_lo;
  logic signed [Y_W-1:0]   ysat;
  logic                    accept;

  assign in_ready = (state == ST_IDLE);
  assign accept   = in_ready && in_valid && !clr;

  iir_pole_coef_bank u_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (coef_we),
    .addr  (coef_addr),
    .data  (coef_data),
    .latch (accept),
    .sel   (k),
    .coef  (coef)
  );

  // History tap Y[n-k] for the current MAC step.
  always_comb begin
    hist_sel = '0;
    for (int unsigned i = 0; i < TAPS; i++)
      if (k == 3'(i + 1))
        hist_sel = hist[i];
  end

  assign prod   = coef * hist_sel;
  assign sum    = acc + HALF;
  assign rnd    = sum >>> COEF_FRAC;
  assign sat_hi = rnd > YMAX;
  assign sat_lo = rnd < YMIN;
  assign ysat   = sat_hi ? 32'sh7FFF_FFFF : sat_lo ? 32'sh8000_0000 : rnd[Y_W-1:0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next;
  end

  // Next-state: clr aborts any sample in flight.
  always_comb begin
    next = state;
    unique case (state)
      ST_IDLE: if (accept) next = ST_MAC;
      ST_MAC:  if (clr) next = ST_IDLE; else if (k == 3'd7) next = ST_OUT;
      ST_OUT:  next = ST_IDLE;
      default: next = ST_IDLE;
    endcase
  end

  // Accumulator, tap counter, history, output and saturation flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      k         <= '0;
      Yout      <= '0;
      out_valid <= 1'b0;
      sat_flag  <= 1'b0;
      for (int unsigned i = 0; i < TAPS; i++) hist[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      if (clr) begin
        sat_flag <= 1'b0;
        for (int unsigned i = 0; i < TAPS; i++) hist[i] <= '0;
      end else begin
        unique case (state)
          ST_IDLE: if (in_valid) begin
            acc <= {{(ACC_W-X_W){Xin[X_W-1]}}, Xin};
            k   <= 3'd1;
          end
          ST_MAC: begin
            acc <= acc - {{(ACC_W-P_W){prod[P_W-1]}}, prod};
            k   <= k + 3'd1;
          end
          ST_OUT: begin
            Yout      <= ysat;
            out_valid <= 1'b1;
            if (sat_hi || sat_lo) sat_flag <= 1'b1;
            hist[0] <= ysat;
            for (int unsigned i = 1; i < TAPS; i++) hist[i] <= hist[i-1];
          end
          default: ;
        endcase
      end
    end
  end

endmodule
